// File: rtl/line_merge_buf_if.sv
// Bus bundle for line_merge_buf: system write port, line-fetch port,
// write-back port and status. The master side is the surrounding system,
// the slave side is the merge buffer itself.
interface line_merge_buf_if #(
  parameter int LINE_WIDTH   = 64,
  parameter int WORD_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 3,
  parameter int ADDR_WIDTH   = 32
);
  // System write port
  logic                               sys_wr_valid;
  logic                               sys_wr_ready;
  logic [ADDR_WIDTH-1:0]              sys_addr;
  logic [WORD_WIDTH-1:0]              sys_wdata;
  logic [WORD_WIDTH/8-1:0]            sys_bval;
  logic                               flush;

  // Line fetch
  logic                               rd_req;
  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] rd_addr;
  logic                               rd_valid;
  logic [LINE_WIDTH-1:0]              rd_data;

  // Line write-back
  logic                               wb_valid;
  logic                               wb_ready;
  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] wb_addr;
  logic [LINE_WIDTH-1:0]              wb_data;

  logic                               busy;

  modport master (
    output sys_wr_valid, sys_addr, sys_wdata, sys_bval, flush,
    output rd_valid, rd_data, wb_ready,
    input  sys_wr_ready, rd_req, rd_addr, wb_valid, wb_addr, wb_data, busy
  );

  modport slave (
    input  sys_wr_valid, sys_addr, sys_wdata, sys_bval, flush,
    input  rd_valid, rd_data, wb_ready,
    output sys_wr_ready, rd_req, rd_addr, wb_valid, wb_addr, wb_data, busy
  );
endinterface

// File: rtl/line_merge_buf.sv
// Single-line write-merge buffer. A write to an absent line fetches the
// line, merges the write into it and holds it so that further writes to the
// same line merge locally. The line is written back on flush, on a write to
// a different line, or after IDLE_LIMIT consecutive HOLD cycles without an
// accepted write.
module line_merge_buf #(
  parameter int LINE_WIDTH   = 64,
  parameter int WORD_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 3,
  parameter int ADDR_WIDTH   = 32,
  parameter int IDLE_LIMIT   = 15
) (
  input logic              clk,
  input logic              rst_n,
  line_merge_buf_if.slave  bus
);

  localparam int WORD_BYTES = WORD_WIDTH / 8;
  localparam int BYTE_LSB   = $clog2(WORD_BYTES);
  localparam int LADDR_W    = ADDR_WIDTH - OFFSET_WIDTH;
  localparam logic [7:0] CNT_LIMIT = 8'(IDLE_LIMIT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cap_addr;
  logic [WORD_WIDTH-1:0] r_cap_wdata;
  logic [WORD_BYTES-1:0] r_cap_bval;
  logic [LINE_WIDTH-1:0] r_buf;
  logic [LADDR_W-1:0]    r_tag;
  logic [7:0]            r_idle_cnt;
  logic                  r_rd_req;

  logic [LADDR_W-1:0]    w_line_addr;
  logic                  w_line_hit;
  logic                  w_wr_ready;

  // Overlay the enabled bytes of one word onto a line; the word slot comes
  // from the byte offset with the within-word byte bits dropped.
  function automatic logic [LINE_WIDTH-1:0] merge(
    input logic [LINE_WIDTH-1:0]   line,
    input logic [OFFSET_WIDTH-1:0] off,
    input logic [WORD_WIDTH-1:0]   wdata,
    input logic [WORD_BYTES-1:0]   bval
  );
    logic [LINE_WIDTH-1:0] res;
    int                    base;
    res  = line;
    base = int'(off >> BYTE_LSB) * WORD_WIDTH;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (bval[b]) res[base + b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  assign w_line_addr = bus.sys_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign w_line_hit  = (w_line_addr == r_tag);

  // Write acceptance: always in IDLE, in HOLD only for the held line and
  // only when no flush is pending (flush wins over a same-line write).
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_wr_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_wr_ready = 1'b1;
      ST_HOLD: w_wr_ready = !bus.flush && w_line_hit;
      default: w_wr_ready = 1'b0;
    endcase
  end

  assign bus.sys_wr_ready = w_wr_ready;
  assign bus.rd_req       = r_rd_req;
  assign bus.rd_addr      = r_cap_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign bus.wb_valid     = (r_state == ST_WB);
  assign bus.wb_addr      = r_tag;
  assign bus.wb_data      = r_buf;
  assign bus.busy         = (r_state != ST_IDLE);

  // State machine, fetch request pulse, line buffer and idle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the line buffer is a plain register, not a RAM, so it is cleared
      // here; an abandoned fill must leave no stale data visible on wb_data.
      r_state     <= ST_IDLE;
      r_cap_addr  <= '0;
      r_cap_wdata <= '0;
      r_cap_bval  <= '0;
      r_buf       <= '0;
      r_tag       <= '0;
      r_idle_cnt  <= '0;
      r_rd_req    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_rd_req <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.sys_wr_valid) begin
            r_cap_addr  <= bus.sys_addr;
            r_cap_wdata <= bus.sys_wdata;
            r_cap_bval  <= bus.sys_bval;
            r_rd_req    <= 1'b1;
            r_state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (bus.rd_valid) begin
            r_buf      <= merge(bus.rd_data, r_cap_addr[OFFSET_WIDTH-1:0],
                                r_cap_wdata, r_cap_bval);
            r_tag      <= r_cap_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
            r_idle_cnt <= '0;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.flush) begin
            r_state <= ST_WB;
          end else if (bus.sys_wr_valid && w_line_hit) begin
            r_buf      <= merge(r_buf, bus.sys_addr[OFFSET_WIDTH-1:0],
                                bus.sys_wdata, bus.sys_bval);
            r_idle_cnt <= '0;
          end else if (bus.sys_wr_valid) begin
            r_state <= ST_WB;
          end else begin
            if (r_idle_cnt != 8'hFF) r_idle_cnt <= r_idle_cnt + 8'd1;
            if (r_idle_cnt >= CNT_LIMIT - 8'd1) r_state <= ST_WB;
          end
        end
        ST_WB: begin
          if (bus.wb_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_merge_buf.sv
// Self-checking bench for line_merge_buf: directed scenarios followed by
// randomized line sessions. Expected write-backs go into a scoreboard queue
// and a monitor compares them whenever wb_valid is presented.
module tb_line_merge_buf;

  localparam int LW  = 64;
  localparam int WW  = 32;
  localparam int OW  = 3;
  localparam int AW  = 32;
  localparam int IL  = 7;
  localparam int WBY = WW / 8;
  localparam int LBY = LW / 8;
  localparam int LA  = AW - OW;

  localparam int M_FLUSH    = 0;
  localparam int M_FLUSH_WR = 1;
  localparam int M_TIMEOUT  = 2;
  localparam int M_MISS     = 3;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [WW-1:0]  data;
    logic [WBY-1:0] bval;
  } wr_t;

  typedef struct {
    logic [LA-1:0] addr;
    logic [LW-1:0] data;
  } wb_t;

  logic clk;
  logic rst_n;

  line_merge_buf_if #(.LINE_WIDTH(LW), .WORD_WIDTH(WW), .OFFSET_WIDTH(OW),
                      .ADDR_WIDTH(AW)) bus ();

  line_merge_buf #(.LINE_WIDTH(LW), .WORD_WIDTH(WW), .OFFSET_WIDTH(OW),
                   .ADDR_WIDTH(AW), .IDLE_LIMIT(IL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  wb_t  exp_q[$];
  wr_t  hold_q[$];
  logic [7:0] mline [LBY];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference line as a byte array: a write covers the aligned word
  // containing its byte address, byte i of the word taking data byte i.
  task automatic model_load(input logic [LW-1:0] d);
    for (int b = 0; b < LBY; b++) mline[b] = d[b*8 +: 8];
  endtask

  task automatic model_write(input wr_t w);
    int first_byte;
    first_byte = (int'(w.addr[OW-1:0]) / WBY) * WBY;
    for (int i = 0; i < WBY; i++)
      if (w.bval[i]) mline[first_byte + i] = w.data[i*8 +: 8];
  endtask

  function automatic logic [LW-1:0] model_line();
    logic [LW-1:0] r;
    for (int b = 0; b < LBY; b++) r[b*8 +: 8] = mline[b];
    return r;
  endfunction

  function automatic wr_t rand_wr(input logic [LA-1:0] la);
    wr_t w;
    w.addr = {la, OW'($urandom)};
    w.data = $urandom;
    w.bval = ($urandom_range(0, 3) == 0) ? '0 : WBY'($urandom);
    return w;
  endfunction

  task automatic drive_write(input wr_t w);
    bus.sys_wr_valid = 1'b1;
    bus.sys_addr     = w.addr;
    bus.sys_wdata    = w.data;
    bus.sys_bval     = w.bval;
  endtask

  task automatic push_exp(input logic [LA-1:0] la, input logic [LW-1:0] d);
    wb_t e;
    e.addr = la;
    e.data = d;
    exp_q.push_back(e);
    n_push++;
  endtask

  // One full line session: IDLE accept, fill, same-line writes from hold_q,
  // an ending event, then write-back with bp cycles of backpressure.
  // Entered and left just after a rising edge.
  task automatic run_line(input wr_t first, input logic [LW-1:0] rdd,
                          input int fill_dly, input int mode, input wr_t miss,
                          input int bp, input logic use_fixed,
                          input logic [LW-1:0] fixed_data);
    logic [LA-1:0] la;
    logic [LW-1:0] exp_data;
    la = first.addr[AW-1:OW];

    drive_write(first);
    @(negedge clk);
    check("idle_ready", bus.sys_wr_ready, 1'b1);
    check("idle_busy", bus.busy, 1'b0);
    step();
    bus.sys_wr_valid = 1'b0;

    for (int c = 0; c <= fill_dly; c++) begin
      if (c == fill_dly) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = rdd;
      end
      @(negedge clk);
      check("fill_rd_req", bus.rd_req, (c == 0));
      check("fill_rd_addr", bus.rd_addr, la);
      check("fill_ready", bus.sys_wr_ready, 1'b0);
      step();
    end
    bus.rd_valid = 1'b0;
    bus.rd_data  = {$urandom, $urandom};
    model_load(rdd);
    model_write(first);

    foreach (hold_q[i]) begin
      int gap;
      gap = $urandom_range(0, IL - 1);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("hold_no_wb", bus.wb_valid, 1'b0);
        step();
      end
      drive_write(hold_q[i]);
      @(negedge clk);
      check("hold_ready", bus.sys_wr_ready, 1'b1);
      step();
      bus.sys_wr_valid = 1'b0;
      model_write(hold_q[i]);
    end
    hold_q.delete();

    exp_data = use_fixed ? fixed_data : model_line();
    push_exp(la, exp_data);
    case (mode)
      M_FLUSH, M_FLUSH_WR: begin
        bus.flush = 1'b1;
        if (mode == M_FLUSH_WR) drive_write(rand_wr(la));
        @(negedge clk);
        check("flush_ready", bus.sys_wr_ready, 1'b0);
        step();
        bus.flush        = 1'b0;
        bus.sys_wr_valid = 1'b0;
      end
      M_TIMEOUT: begin
        for (int c = 0; c < IL; c++) begin
          @(negedge clk);
          check("timeout_early_wb", bus.wb_valid, 1'b0);
          check("timeout_busy", bus.busy, 1'b1);
          step();
        end
      end
      default: begin
        drive_write(miss);
        @(negedge clk);
        check("miss_ready", bus.sys_wr_ready, 1'b0);
        step();
      end
    endcase

    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check("wb_valid_hold", bus.wb_valid, 1'b1);
      check("wb_ready_low", bus.sys_wr_ready, 1'b0);
      step();
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    check("wb_valid", bus.wb_valid, 1'b1);
    step();
    bus.wb_ready = 1'b0;
    if (mode != M_MISS) begin
      @(negedge clk);
      check("post_wb_busy", bus.busy, 1'b0);
      check("post_wb_valid", bus.wb_valid, 1'b0);
      step();
    end
  endtask

  // Scoreboard monitor: the head entry must be presented unchanged for as
  // long as wb_valid is high, and retires on the handshake.
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wb_unexpected: got addr %0h data %0h, expected no write-back",
                 bus.wb_addr, bus.wb_data);
      end else begin
        check("sb_wb_addr", bus.wb_addr, exp_q[0].addr);
        check("sb_wb_data", bus.wb_data, exp_q[0].data);
        if (bus.wb_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_t  w0, w1, miss, nxt;
    logic have_nxt;
    int   mode;

    rst_n            = 1'b0;
    bus.sys_wr_valid = 1'b0;
    bus.sys_addr     = '0;
    bus.sys_wdata    = '0;
    bus.sys_bval     = '0;
    bus.flush        = 1'b0;
    bus.rd_valid     = 1'b0;
    bus.rd_data      = '0;
    bus.wb_ready     = 1'b0;
    miss             = '{addr: '0, data: '0, bval: '0};

    step();
    step();
    @(negedge clk);
    check("rst_rd_req", bus.rd_req, 1'b0);
    check("rst_wb_valid", bus.wb_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rd_addr", bus.rd_addr, '0);
    check("rst_wb_addr", bus.wb_addr, '0);
    check("rst_wb_data", bus.wb_data, '0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", bus.sys_wr_ready, 1'b1);
    step();

    // Single write then flush
    w0 = '{addr: 32'h104, data: 32'hAABBCCDD, bval: 4'b0101};
    run_line(w0, 64'h1111_2222_3333_4444, 1, M_FLUSH, miss, 0,
             1'b1, 64'h11BB_22DD_3333_4444);

    // Two merged writes, idle write-back
    w0 = '{addr: 32'h100, data: 32'h01020304, bval: 4'hF};
    w1 = '{addr: 32'h104, data: 32'hFF000000, bval: 4'b1000};
    hold_q.push_back(w1);
    run_line(w0, '0, 0, M_TIMEOUT, miss, 0, 1'b1, 64'hFF00_0000_0102_0304);

    // Line change, retried write goes through the next session with
    // long write-back backpressure
    w0   = '{addr: 32'h100, data: 32'h0000_00A5, bval: 4'b0001};
    miss = '{addr: 32'h208, data: 32'h1234_5678, bval: 4'hF};
    run_line(w0, 64'h0, 2, M_MISS, miss, 0, 1'b1, 64'h0000_0000_0000_00A5);
    run_line(miss, 64'hFFFF_FFFF_FFFF_FFFF, 0, M_FLUSH, miss, 10,
             1'b1, 64'hFFFF_FFFF_1234_5678);

    // Flush beats a same-line write
    w0 = '{addr: 32'h300, data: 32'hCAFEBABE, bval: 4'hF};
    run_line(w0, '0, 1, M_FLUSH_WR, miss, 1, 1'b1, 64'h0000_0000_CAFE_BABE);

    // Zero byte-enable write keeps data but restarts the idle count
    w0 = '{addr: 32'h500, data: 32'h0BAD_F00D, bval: 4'h0};
    hold_q.push_back('{addr: 32'h504, data: 32'hDEAD_BEEF, bval: 4'h0});
    run_line(w0, 64'h7766_5544_3322_1100, 0, M_TIMEOUT, miss, 0,
             1'b1, 64'h7766_5544_3322_1100);

    // Reset during FILL, late rd_valid must be ignored
    drive_write('{addr: 32'h400, data: 32'h5555_5555, bval: 4'hF});
    @(negedge clk);
    check("r39_ready", bus.sys_wr_ready, 1'b1);
    step();
    bus.sys_wr_valid = 1'b0;
    rst_n            = 1'b0;
    step();
    rst_n        = 1'b1;
    bus.rd_valid = 1'b1;
    bus.rd_data  = 64'h9999_8888_7777_6666;
    @(negedge clk);
    check("r39_busy_rel", bus.busy, 1'b0);
    check("r39_rd_req", bus.rd_req, 1'b0);
    step();
    bus.rd_valid = 1'b0;
    @(negedge clk);
    check("r39_busy", bus.busy, 1'b0);
    check("r39_wb_valid", bus.wb_valid, 1'b0);
    check("r39_wb_data", bus.wb_data, '0);
    check("r39_wb_addr", bus.wb_addr, '0);
    check("r39_ready_after", bus.sys_wr_ready, 1'b1);
    step();

    // Randomized sessions
    have_nxt = 1'b0;
    nxt      = miss;
    for (int it = 0; it < 40; it++) begin
      wr_t fw;
      int  nh;
      fw = have_nxt ? nxt : rand_wr(LA'($urandom));
      nh = $urandom_range(0, 3);
      for (int h = 0; h < nh; h++) hold_q.push_back(rand_wr(fw.addr[AW-1:OW]));
      mode = (it == 39) ? M_FLUSH : $urandom_range(0, 3);
      miss = rand_wr(fw.addr[AW-1:OW] ^ LA'($urandom_range(1, 255)));
      run_line(fw, {$urandom, $urandom}, $urandom_range(0, 3), mode, miss,
               $urandom_range(0, 4), 1'b0, '0);
      have_nxt = (mode == M_MISS);
      nxt      = miss;
    end

    repeat (3) step();
    check("sb_empty", exp_q.size(), 0);
    check("sb_retired", n_pop, n_push);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
